bytecode_loader: RTL and testbench
==================================

BYTECODE_LOADER -- requirements
Module: bytecode_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, program memory depth in bytes.
REQ-002 SHALL have parameter TERM_BYTE, default 8'hFF, end-of-program marker.
REQ-003 SHALL have parameter RUN_TIMEOUT, default 4096, max cycles waiting for cpu_running to rise.
REQ-004 SHALL have port clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port load_req  in  1  one-cycle pulse that starts a load.
REQ-007 SHALL have ports s_valid in 1, s_data in 8, s_last in 1, s_ready out 1  byte stream, valid/ready.
REQ-008 SHALL have ports mem_we out 1, mem_addr out 10, mem_wdata out 8  program memory write port.
REQ-009 SHALL have ports cpu_enable out 1, cpu_running in 1, cpu_result in 8  microprocessor control.
REQ-010 SHALL have ports result out 8, result_valid out 1, busy out 1, error out 1, load_count out 11.

Function
REQ-011 SHALL implement states IDLE, LOAD, TERM, START, RUN, DONE, ERR.
REQ-012 SHALL move IDLE->LOAD on load_req, clearing address counter, load_count, error.
REQ-013 SHALL assert s_ready only in LOAD with address counter < DEPTH-1.
REQ-014 SHALL, per accepted byte (s_valid&s_ready), assert mem_we the next cycle with mem_addr=counter, mem_wdata=s_data, then increment counter and load_count.
REQ-015 SHALL move LOAD->TERM when the accepted byte has s_last=1.
REQ-016 SHALL, in TERM, write TERM_BYTE at the current counter (one mem_we cycle), then go to START.
REQ-017 SHALL, if counter reaches DEPTH-1 in LOAD without s_last, write TERM_BYTE at DEPTH-1, set error, go to ERR; cpu_enable never asserts.
REQ-018 SHALL, in START, assert cpu_enable and go to RUN the next cycle; cpu_enable stays high through RUN.
REQ-019 SHALL, in RUN, wait for cpu_running=1, then for cpu_running=0; on the falling edge, register result=cpu_result, pulse result_valid one cycle, drop cpu_enable, go to DONE.
REQ-020 SHALL, if cpu_running stays 0 for RUN_TIMEOUT cycles after entering RUN, drop cpu_enable, set error, go to ERR.
REQ-021 SHALL return DONE->LOAD and ERR->LOAD on load_req (same clearing as REQ-012); load_req is ignored in LOAD, TERM, START, RUN.
REQ-022 SHALL drive busy=1 in LOAD, TERM, START, RUN; 0 otherwise.
REQ-023 SHALL hold result stable from capture until the next capture or reset.
REQ-024 SHALL treat s_last with zero prior bytes (single byte) normally: byte at 0, TERM_BYTE at 1.
REQ-025 SHALL ignore s_data contents; a data byte equal to TERM_BYTE is stored unchanged.

Reset
REQ-026 SHALL, on rst_n=0, immediately enter IDLE and clear s_ready, mem_we, mem_addr, mem_wdata, cpu_enable, result, result_valid, busy, error, load_count, counters.
REQ-027 SHALL abort any load or run on mid-operation reset with no further memory write; cpu_enable drops asynchronously.
REQ-028 SHALL leave reset synchronously: first active state change no earlier than the first rising clk after rst_n rises.

Structure
REQ-029 SHALL take the state enumeration, TERM_BYTE default and the 10-bit address width from the shared microprocessor package.
REQ-030 SHALL be a single module with no sub-modules; the timeout counter is inline.

Verification
REQ-031 SHALL check: load_req, bytes 8'h01,8'h02,8'h03 (last on 03) -> writes addr0..2 = 01,02,03, addr3 = FF, then cpu_enable=1, load_count=3.
REQ-032 SHALL check: after enable, model cpu_running high 10 cycles then low with cpu_result=8'h2A -> result=8'h2A, one-cycle result_valid, cpu_enable=0, state DONE.
REQ-033 SHALL check: 1023 bytes without s_last -> s_ready low after 1023rd, addr 1023 = FF, error=1, cpu_enable never 1.
REQ-034 SHALL check: cpu_running held 0 -> after 4096 cycles in RUN, error=1, cpu_enable=0.
REQ-035 SHALL check: rst_n low mid-load at byte 5 -> outputs zero at once, no mem_we thereafter; a new load_req restarts at addr 0.
REQ-036 SHALL check: s_valid toggled randomly with s_ready backpressure -> every byte written once, in order, no gaps.

Source files
------------

// File: rtl/bytecode_loader_pkg.sv
// ---------------------------------------------------------------------------
// bytecode_loader_pkg
//   Shared microprocessor definitions used by the bytecode loader: the
//   program-memory address width, the default end-of-program marker and the
//   loader state enumeration.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
package bytecode_loader_pkg;

  localparam int unsigned ADDR_W        = 10;
  localparam logic [7:0]  TERM_BYTE_DEF = 8'hFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_TERM,
    S_START,
    S_RUN,
    S_DONE,
    S_ERR
  } state_e;

endpackage

// File: rtl/bytecode_loader.sv
// ---------------------------------------------------------------------------
// bytecode_loader
//   Streams a program (valid/ready byte stream) into program memory, appends
//   an end-of-program marker, starts the microprocessor and captures its
//   result when it finishes running.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   load_req              one-cycle pulse that starts a load (IDLE/DONE/ERR)
//   s_valid/s_data/s_last byte stream in, s_ready out
//   mem_we/addr/wdata     program memory write port (registered)
//   cpu_enable            held high through START and RUN
//   cpu_running           processor activity, cpu_result its result byte
//   result/result_valid   captured result, one-cycle valid pulse
//   busy                  high in LOAD, TERM, START, RUN
//   error                 overflow or run timeout
//   load_count            number of stream bytes accepted this load
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module bytecode_loader
  import bytecode_loader_pkg::*;
#(
  parameter int unsigned DEPTH       = 1024,
  parameter logic [7:0]  TERM_BYTE   = TERM_BYTE_DEF,
  parameter int unsigned RUN_TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_req,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_enable,
  input  logic              cpu_running,
  input  logic [7:0]        cpu_result,
  output logic [7:0]        result,
  output logic              result_valid,
  output logic              busy,
  output logic              error,
  output logic [ADDR_W:0]   load_count
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam int unsigned       TMO_W     = $clog2(RUN_TIMEOUT + 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(RUN_TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W:0]   lc_q, lc_d;
  logic              err_q, err_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [7:0]        res_q, res_d;
  logic              rv_q, rv_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              seen_q, seen_d;   // cpu_running has been observed high
  logic              accept;

  // Outputs decoded from state so that reset drops them asynchronously.
  assign s_ready    = (state_q == S_LOAD) && (cnt_q < LAST_ADDR);
  assign cpu_enable = (state_q == S_START) || (state_q == S_RUN);
  assign busy       = (state_q == S_LOAD) || (state_q == S_TERM) ||
                      (state_q == S_START) || (state_q == S_RUN);
  assign accept     = s_valid && s_ready;

  assign mem_we       = we_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign result       = res_q;
  assign result_valid = rv_q;
  assign error        = err_q;
  assign load_count   = lc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      lc_q    <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      res_q   <= '0;
      rv_q    <= 1'b0;
      tmo_q   <= '0;
      seen_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lc_q    <= lc_d;
      err_q   <= err_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      res_q   <= res_d;
      rv_q    <= rv_d;
      tmo_q   <= tmo_d;
      seen_q  <= seen_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lc_d    = lc_q;
    err_d   = err_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    res_d   = res_q;
    rv_d    = 1'b0;
    tmo_d   = tmo_q;
    seen_d  = seen_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (load_req) begin
          state_d = S_LOAD;
          cnt_d   = '0;
          lc_d    = '0;
          err_d   = 1'b0;
        end
      end

      S_LOAD: begin
        if (accept) begin
          we_d    = 1'b1;
          addr_d  = cnt_q;
          wdata_d = s_data;
          cnt_d   = cnt_q + 1'b1;
          lc_d    = lc_q + 1'b1;
          if (s_last) state_d = S_TERM;
        end else if (cnt_q == LAST_ADDR) begin
          // Memory full without s_last: seal it with the marker and fail.
          we_d    = 1'b1;
          addr_d  = LAST_ADDR;
          wdata_d = TERM_BYTE;
          err_d   = 1'b1;
          state_d = S_ERR;
        end
      end

      S_TERM: begin
        we_d    = 1'b1;
        addr_d  = cnt_q;
        wdata_d = TERM_BYTE;
        state_d = S_START;
      end

      S_START: begin
        tmo_d   = '0;
        seen_d  = 1'b0;
        state_d = S_RUN;
      end

      S_RUN: begin
        if (cpu_running) begin
          seen_d = 1'b1;
        end else if (seen_q) begin
          res_d   = cpu_result;
          rv_d    = 1'b1;
          state_d = S_DONE;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = S_ERR;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_bytecode_loader.sv
`timescale 1ns/1ps
module tb_bytecode_loader;
  import bytecode_loader_pkg::*;

  localparam int unsigned DEPTH       = 1024;
  localparam int unsigned RUN_TIMEOUT = 4096;
  localparam logic [7:0]  TB_TERM     = 8'hFF;

  logic              clk;
  logic              rst_n;
  logic              load_req;
  logic              s_valid;
  logic [7:0]        s_data;
  logic              s_last;
  logic              s_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              cpu_enable;
  logic              cpu_running;
  logic [7:0]        cpu_result;
  logic [7:0]        result;
  logic              result_valid;
  logic              busy;
  logic              error;
  logic [ADDR_W:0]   load_count;

  bytecode_loader #(
    .DEPTH(DEPTH),
    .TERM_BYTE(TB_TERM),
    .RUN_TIMEOUT(RUN_TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .load_req(load_req),
    .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_enable(cpu_enable), .cpu_running(cpu_running), .cpu_result(cpu_result),
    .result(result), .result_valid(result_valid), .busy(busy),
    .error(error), .load_count(load_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;

  // Observed memory write log and reference program.
  logic [ADDR_W-1:0] wr_addr[$];
  logic [7:0]        wr_data[$];
  logic [7:0]        prog[$];
  bit                en_seen;

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
    end
    if (cpu_enable === 1'b1) en_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_s_ready"}, 32'(s_ready), 0);
    check({tag, "_mem_we"}, 32'(mem_we), 0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 0);
    check({tag, "_mem_wdata"}, 32'(mem_wdata), 0);
    check({tag, "_cpu_enable"}, 32'(cpu_enable), 0);
    check({tag, "_result"}, 32'(result), 0);
    check({tag, "_result_valid"}, 32'(result_valid), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_error"}, 32'(error), 0);
    check({tag, "_load_count"}, 32'(load_count), 0);
  endtask

  task automatic pulse_load();
    wr_addr.delete();
    wr_data.delete();
    load_req = 1'b1;
    step();
    load_req = 1'b0;
    check("load_busy", 32'(busy), 1);
    check("load_cnt_clr", 32'(load_count), 0);
    check("load_err_clr", 32'(error), 0);
    check("load_ready", 32'(s_ready), 1);
  endtask

  // Present prog[] on the stream; valid asserted with probability pct%.
  task automatic send_prog(input int pct, input bit with_last);
    int idx;
    int budget;
    bit acc;
    idx = 0;
    budget = prog.size() * 40 + 100;
    while (idx < prog.size() && budget > 0) begin
      s_valid = ($urandom_range(99) < pct);
      s_data  = s_valid ? prog[idx] : 8'($urandom);
      s_last  = s_valid ? (with_last && (idx == prog.size() - 1)) : 1'($urandom_range(1));
      acc = s_valid && s_ready;
      step();
      if (acc) idx++;
      budget--;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = 8'($urandom);
    check("send_done", idx, prog.size());
  endtask

  task automatic wait_enable();
    int n;
    n = 0;
    while (cpu_enable !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check("enable_rise", 32'(cpu_enable), 1);
    check("enable_latency", n, 1);
  endtask

  // Expected: prog[i] at address i, then the marker at term_addr.
  task automatic check_writes(input int term_addr);
    logic [ADDR_W-1:0] ea[$];
    logic [7:0]        ed[$];
    int n;
    for (int i = 0; i < prog.size(); i++) begin
      ea.push_back(ADDR_W'(i));
      ed.push_back(prog[i]);
    end
    ea.push_back(ADDR_W'(term_addr));
    ed.push_back(TB_TERM);
    check("wr_count", wr_addr.size(), ea.size());
    n = (wr_addr.size() < ea.size()) ? wr_addr.size() : ea.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("wr_addr[%0d]", i), 32'(wr_addr[i]), 32'(ea[i]));
      check($sformatf("wr_data[%0d]", i), 32'(wr_data[i]), 32'(ed[i]));
    end
  endtask

  // Called in START with cpu_enable high.
  task automatic run_cpu(input int lo, input int hi, input logic [7:0] res);
    cpu_running = 1'b0;
    repeat (lo) step();
    cpu_running = 1'b1;
    repeat (hi) step();
    check("run_enable_held", 32'(cpu_enable), 1);
    check("run_busy", 32'(busy), 1);
    cpu_running = 1'b0;
    cpu_result  = res;
    step();
    check("run_result", 32'(result), 32'(res));
    check("run_rvalid", 32'(result_valid), 1);
    check("run_enable_drop", 32'(cpu_enable), 0);
    check("run_busy_drop", 32'(busy), 0);
    check("run_no_error", 32'(error), 0);
    check("run_state_done", 32'(dut.state_q), 32'(S_DONE));
    cpu_result = 8'($urandom);
    step();
    check("run_rvalid_pulse", 32'(result_valid), 0);
    check("run_result_hold", 32'(result), 32'(res));
  endtask

  initial begin
    logic [7:0] res;
    int n;
    load_req    = 1'b0;
    s_valid     = 1'b0;
    s_data      = '0;
    s_last      = 1'b0;
    cpu_running = 1'b0;
    cpu_result  = '0;
    en_seen     = 1'b0;
    rst_n       = 1'b1;
    #1 rst_n = 1'b0;
    #1 check_all_zero("reset");
    repeat (3) step();
    rst_n = 1'b1;
    step();
    check("idle_after_reset", 32'(busy), 0);

    // Three-byte program, run reporting 0x2A.
    pulse_load();
    prog = '{8'h01, 8'h02, 8'h03};
    send_prog(100, 1'b1);
    check("basic_load_count", 32'(load_count), 3);
    wait_enable();
    run_cpu(0, 10, 8'h2A);
    check_writes(3);

    // Single-byte program with a data byte equal to the marker.
    pulse_load();
    check("result_kept_on_load", 32'(result), 32'h2A);
    prog = '{TB_TERM};
    send_prog(100, 1'b1);
    check("single_load_count", 32'(load_count), 1);
    wait_enable();
    res = 8'($urandom);
    run_cpu(1, 2, res);
    check_writes(1);

    // Random programs with random valid backpressure.
    for (int it = 0; it < 4; it++) begin
      pulse_load();
      prog.delete();
      n = $urandom_range(40, 2);
      for (int i = 0; i < n; i++)
        prog.push_back(($urandom_range(7) == 0) ? TB_TERM : 8'($urandom));
      send_prog(50, 1'b1);
      check("rand_load_count", 32'(load_count), n);
      wait_enable();
      res = 8'($urandom);
      run_cpu($urandom_range(5), $urandom_range(12, 2), res);
      check_writes(n);
    end

    // Run timeout with cpu_running held low.
    pulse_load();
    prog = '{8'h11, 8'h22};
    send_prog(100, 1'b1);
    wait_enable();
    cpu_running = 1'b0;
    n = 0;
    while (error !== 1'b1 && n < RUN_TIMEOUT + 100) begin
      step();
      n++;
    end
    check("timeout_error", 32'(error), 1);
    check("timeout_cycles", n, RUN_TIMEOUT + 1);
    check("timeout_enable", 32'(cpu_enable), 0);
    check("timeout_busy", 32'(busy), 0);
    check("timeout_state", 32'(dut.state_q), 32'(S_ERR));
    check("timeout_result_hold", 32'(result), 32'(res));

    // Overflow: DEPTH-1 bytes without s_last.
    pulse_load();
    en_seen = 1'b0;
    prog.delete();
    for (int i = 0; i < DEPTH - 1; i++) prog.push_back(8'($urandom));
    send_prog(100, 1'b0);
    check("ovf_ready_low", 32'(s_ready), 0);
    check("ovf_load_count", 32'(load_count), DEPTH - 1);
    check("ovf_no_err_yet", 32'(error), 0);
    step();
    check("ovf_error", 32'(error), 1);
    check("ovf_we", 32'(mem_we), 1);
    check("ovf_addr", 32'(mem_addr), DEPTH - 1);
    check("ovf_wdata", 32'(mem_wdata), 32'(TB_TERM));
    check("ovf_busy", 32'(busy), 0);
    repeat (3) step();
    check_writes(DEPTH - 1);
    check("ovf_enable_never", 32'(en_seen), 0);

    // Reset in the middle of a load, right as the fifth byte is written.
    pulse_load();
    prog = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
    send_prog(100, 1'b0);
    rst_n = 1'b0;
    #1 check_all_zero("midload_reset");
    wr_addr.delete();
    wr_data.delete();
    s_valid = 1'b1;
    s_data  = 8'h55;
    repeat (3) step();
    rst_n = 1'b1;
    repeat (3) step();
    s_valid = 1'b0;
    check("midload_no_writes", wr_addr.size(), 0);
    check("midload_idle", 32'(busy), 0);
    pulse_load();
    prog = '{8'h5A, 8'hC3};
    send_prog(70, 1'b1);
    wait_enable();
    res = 8'($urandom);
    run_cpu(2, 4, res);
    check_writes(2);

    // Reset while running drops cpu_enable at once.
    pulse_load();
    prog = '{8'h77};
    send_prog(100, 1'b1);
    wait_enable();
    cpu_running = 1'b1;
    repeat (3) step();
    check("run_before_reset", 32'(cpu_enable), 1);
    rst_n = 1'b0;
    #1;
    check("run_reset_enable", 32'(cpu_enable), 0);
    check("run_reset_busy", 32'(busy), 0);
    cpu_running = 1'b0;
    step();
    rst_n = 1'b1;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
